// File: rtl/hazard_ctrl_unit.sv
// Pipeline interlock controller: load-use stalls, mispredict flushes and ECALL halt drain.
// Optional perf counters (stall_cnt/flush_cnt) are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl_unit #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] id_ex_rd,
  input  logic       id_ex_mem_read,
  input  logic       ex_branch_mispredict,
  input  logic       id_is_ecall,
  input  logic       id_halt_cond,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_bubble,
  output logic       is_halted
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]    state, next_state;
  logic [DW-1:0] drain_cnt, next_drain_cnt;
  logic          load_use;
  logic          win_flush, win_stall;

  assign load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == id_ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == id_ex_rd)));

  // Defaults are the freeze pattern shared by reset, DRAIN and HALTED.
  always_comb begin
    pc_write       = 1'b0;
    if_id_write    = 1'b0;
    if_id_flush    = 1'b1;
    id_ex_bubble   = 1'b1;
    is_halted      = 1'b0;
    next_state     = state;
    next_drain_cnt = drain_cnt;
    win_flush      = 1'b0;
    win_stall      = 1'b0;
    if (reset_n) begin
      case (state)
        ST_RUN: begin
          if (ex_branch_mispredict) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            win_flush   = 1'b1;
          end else if (load_use) begin
            if_id_flush = 1'b0;
            win_stall   = 1'b1;
          end else if (id_is_ecall && id_halt_cond) begin
            // The ECALL itself moves into ID/EX; younger fetches are squashed.
            id_ex_bubble   = 1'b0;
            next_state     = ST_DRAIN;
            next_drain_cnt = DW'(DRAIN_CYCLES - 1);
          end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b0;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) next_state = ST_HALTED;
          else                 next_drain_cnt = drain_cnt - DW'(1);
        end
        ST_HALTED: is_halted = 1'b1;
        default:   next_state = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
    end else begin
      state     <= next_state;
      drain_cnt <= next_drain_cnt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (win_stall) stall_cnt <= sat_inc(stall_cnt);
      if (win_flush) flush_cnt <= sat_inc(flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios then randomized traffic
// against a cycle-indexed reference model of the interlock rules.
module tb_hazard_ctrl_unit;
  localparam int DRAIN = 3;
  localparam int CNT_W = 32;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] id_rs1, id_rs2, id_ex_rd;
  logic       id_use_rs1, id_use_rs2, id_ex_mem_read;
  logic       ex_branch_mispredict, id_is_ecall, id_halt_cond;
  logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, is_halted;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  hazard_ctrl_unit #(.DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .ex_branch_mispredict(ex_branch_mispredict), .id_is_ecall(id_is_ecall),
    .id_halt_cond(id_halt_cond),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .is_halted(is_halted)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_fail  = 0;

  // Reference model: the cycle on which a halting ECALL was accepted fixes the whole
  // drain/halt timeline; -1 means no halt pending.
  int          cyc     = 0;
  int          halt_at = -1;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit model_load_use();
    bit hit1, hit2;
    hit1 = id_use_rs1 && (id_rs1 == id_ex_rd);
    hit2 = id_use_rs2 && (id_rs2 == id_ex_rd);
    return id_ex_mem_read && (id_ex_rd != 0) && (hit1 || hit2);
  endfunction

  function automatic bit model_running();
    return (halt_at < 0) || (cyc <= halt_at);
  endfunction

  // Inputs are set 1 time unit after a posedge; this checks mid-cycle then advances the model.
  task automatic step(input string tag);
    logic e_pc, e_ifw, e_fl, e_bub, e_h;
    #3;
    if (!reset_n) begin
      e_pc = 0; e_ifw = 0; e_fl = 1; e_bub = 1; e_h = 0;
    end else if (!model_running()) begin
      e_pc = 0; e_ifw = 0; e_fl = 1; e_bub = 1;
      e_h  = (cyc - halt_at > DRAIN);
    end else if (ex_branch_mispredict) begin
      e_pc = 1; e_ifw = 1; e_fl = 1; e_bub = 1; e_h = 0;
    end else if (model_load_use()) begin
      e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 1; e_h = 0;
    end else if (id_is_ecall && id_halt_cond) begin
      e_pc = 0; e_ifw = 0; e_fl = 1; e_bub = 0; e_h = 0;
    end else begin
      e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_h = 0;
    end
    chk({tag, ".pc_write"},     32'(pc_write),     32'(e_pc));
    chk({tag, ".if_id_write"},  32'(if_id_write),  32'(e_ifw));
    chk({tag, ".if_id_flush"},  32'(if_id_flush),  32'(e_fl));
    chk({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(e_bub));
    chk({tag, ".is_halted"},    32'(is_halted),    32'(e_h));
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, ".stall_cnt"}, stall_cnt, m_stall);
    chk({tag, ".flush_cnt"}, flush_cnt, m_flush);
`endif
    @(posedge clk);
    if (!reset_n) begin
      halt_at = -1; m_stall = 0; m_flush = 0;
    end else if (model_running()) begin
      if (ex_branch_mispredict) begin
        if (m_flush != 32'hFFFF_FFFF) m_flush++;
      end else if (model_load_use()) begin
        if (m_stall != 32'hFFFF_FFFF) m_stall++;
      end else if (id_is_ecall && id_halt_cond) begin
        halt_at = cyc;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle();
    reset_n = 1; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_ex_rd = 0; id_ex_mem_read = 0; ex_branch_mispredict = 0;
    id_is_ecall = 0; id_halt_cond = 0;
  endtask

  initial begin
    idle();
    reset_n = 0;
    #1;
    step("reset0");
    step("reset1");
    idle(); step("run_idle");

    // Load-use on rs1, then release.
    id_ex_mem_read = 1; id_ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; step("lu_rs1");
    idle(); id_rs1 = 5; id_use_rs1 = 1; step("lu_release");
    // x0 destination and unused rs2 never stall.
    idle(); id_ex_mem_read = 1; id_ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1; step("lu_x0");
    idle(); id_ex_mem_read = 1; id_ex_rd = 5; id_rs2 = 5; id_use_rs2 = 0; step("lu_rs2_unused");
    idle(); id_ex_mem_read = 1; id_ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; step("lu_rs2");
    // Mispredict beats load-use.
    idle(); id_ex_mem_read = 1; id_ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    ex_branch_mispredict = 1; step("mp_over_lu");
    // Non-halting ECALL and mispredict-squashed halting ECALL stay in RUN.
    idle(); id_is_ecall = 1; id_halt_cond = 0; step("ecall_nohalt");
    idle(); step("after_nohalt");
    idle(); id_is_ecall = 1; id_halt_cond = 1; ex_branch_mispredict = 1; step("ecall_mp");
    idle(); step("after_ecall_mp");
    // ECALL with its own load-use stalls first, then halts on retry.
    idle(); id_is_ecall = 1; id_halt_cond = 1; id_rs1 = 17; id_use_rs1 = 1;
    id_ex_mem_read = 1; id_ex_rd = 17; step("ecall_lu");
    idle(); id_is_ecall = 1; id_halt_cond = 1; id_rs1 = 17; id_use_rs1 = 1; step("ecall_halt");
    // Drain ignores mispredicts; halt is sticky.
    idle(); ex_branch_mispredict = 1; step("drain1");
    idle(); step("drain2");
    idle(); step("drain3");
    for (int i = 0; i < 20; i++) begin
      idle(); ex_branch_mispredict = i[0]; id_ex_mem_read = 1; id_ex_rd = 3;
      id_rs1 = 3; id_use_rs1 = 1; step("halted");
    end
    idle(); reset_n = 0; step("reset_halted");
    idle(); step("run_after_rst_h");
    // Reset mid-drain.
    idle(); id_is_ecall = 1; id_halt_cond = 1; step("ecall_halt2");
    idle(); step("drain_b1");
    idle(); reset_n = 0; step("reset_drain");
    idle(); step("run_after_rst_d");
    idle(); step("run_after_rst_d2");

    // Randomized traffic with occasional resets so halts do not end the run.
    for (int i = 0; i < 400; i++) begin
      reset_n              = ($urandom_range(0, 39) != 0);
      id_rs1               = 5'($urandom_range(0, 3));
      id_rs2               = 5'($urandom_range(0, 3));
      id_ex_rd             = 5'($urandom_range(0, 3));
      id_use_rs1           = 1'($urandom_range(0, 1));
      id_use_rs2           = 1'($urandom_range(0, 1));
      id_ex_mem_read       = 1'($urandom_range(0, 1));
      ex_branch_mispredict = ($urandom_range(0, 7) == 0);
      id_is_ecall          = ($urandom_range(0, 9) == 0);
      id_halt_cond         = 1'($urandom_range(0, 1));
      step("rand");
    end

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end
endmodule
